leaf_rx_demux: RTL and testbench

//  Receive side of a page's leaf interface. Sits between the BFT leaf output
//  (din_leaf_bft2interface) and the page operator's input streams.

---
 rtl/leaf_rx_demux.sv | 141 ++++++++++++++
 tb/tb_leaf_rx_demux.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_rx_demux.sv
`default_nettype none
// ============================================================================
// Module  : leaf_rx_demux
// Purpose : BFT leaf receive side; checks destination and demuxes payloads
//           into per-port first-word-fall-through FIFOs with resend on drop.
// Revision: 1.0  initial release
// ============================================================================
module leaf_rx_demux #(
    parameter logic [4:0] LEAF_ADDR  = 5'd0,
    parameter int         NUM_PORTS  = 4,
    parameter int         FIFO_DEPTH = 16,
    parameter int         CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [48:0]             din_leaf_bft2interface,
    output logic [NUM_PORTS*32-1:0] dout_data,
    output logic [NUM_PORTS-1:0]    dout_valid,
    input  logic [NUM_PORTS-1:0]    dout_ready,
    output logic                    resend,
    output logic [3:0]              resend_port,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [CNT_W-1:0]        misroute_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [48:0]          pkt_q, pkt_d;
    logic                 resend_q, resend_d;
    logic [3:0]           resend_port_q, resend_port_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]     misroute_cnt_q, misroute_cnt_d;

    logic                 pkt_valid;
    logic [4:0]           pkt_leaf;
    logic [3:0]           pkt_port;
    logic [31:0]          pkt_data;
    logic                 port_in_range;
    logic                 pkt_ok;
    logic                 misroute;
    logic                 drop_any;
    logic [NUM_PORTS-1:0] drop_vec;
    logic                 unused_rsvd;

    assign pkt_valid     = pkt_q[48];
    assign pkt_leaf      = pkt_q[47:43];
    assign pkt_port      = pkt_q[42:39];
    assign pkt_data      = pkt_q[31:0];
    assign unused_rsvd   = ^pkt_q[38:32];
    assign port_in_range = {1'b0, pkt_port} < 5'(NUM_PORTS);
    assign pkt_ok        = pkt_valid && (pkt_leaf == LEAF_ADDR) && port_in_range;
    assign misroute      = pkt_valid && !((pkt_leaf == LEAF_ADDR) && port_in_range);
    assign drop_any      = |drop_vec;

    always_comb begin
        pkt_d          = din_leaf_bft2interface;
        resend_d       = drop_any;
        resend_port_d  = drop_any ? pkt_port : resend_port_q;
        drop_cnt_d     = drop_cnt_q;
        misroute_cnt_d = misroute_cnt_q;
        if (drop_any && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (misroute && (misroute_cnt_q != '1)) begin
            misroute_cnt_d = misroute_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q          <= '0;
            resend_q       <= 1'b0;
            resend_port_q  <= '0;
            drop_cnt_q     <= '0;
            misroute_cnt_q <= '0;
        end else begin
            pkt_q          <= pkt_d;
            resend_q       <= resend_d;
            resend_port_q  <= resend_port_d;
            drop_cnt_q     <= drop_cnt_d;
            misroute_cnt_q <= misroute_cnt_d;
        end
    end

    assign resend       = resend_q;
    assign resend_port  = resend_port_q;
    assign drop_cnt     = drop_cnt_q;
    assign misroute_cnt = misroute_cnt_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [AW:0]  wr_ptr_q, wr_ptr_d;
        logic [AW:0]  rd_ptr_q, rd_ptr_d;
        logic [31:0]  mem_q [FIFO_DEPTH];
        logic         hit;
        logic         empty;
        logic         full;
        logic         pop;
        logic         push;

        assign hit   = pkt_ok && (pkt_port == 4'(p));
        assign empty = (wr_ptr_q == rd_ptr_q);
        assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign pop   = !empty && dout_ready[p];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign push        = hit && (!full || pop);
        assign drop_vec[p] = hit && full && !pop;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= pkt_data;
            end
        end

        assign dout_valid[p]         = !empty;
        assign dout_data[p*32 +: 32] = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule
`default_nettype wire

// File: tb/tb_leaf_rx_demux.sv
`default_nettype none
// ============================================================================
// Module  : tb_leaf_rx_demux
// Purpose : Directed scoreboard bench for leaf_rx_demux.
// Revision: 1.0  initial release
// ============================================================================
module tb_leaf_rx_demux;

    localparam logic [4:0] LEAF  = 5'd0;
    localparam int         NP    = 4;
    localparam int         DEPTH = 16;
    localparam int         CW    = 16;
    localparam int         ACC   = 0;
    localparam int         DRP   = 1;
    localparam int         MIS   = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [48:0]      din;
    logic [NP*32-1:0] dout_data;
    logic [NP-1:0]    dout_valid;
    logic [NP-1:0]    dout_ready;
    logic             resend;
    logic [3:0]       resend_port;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    misroute_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [NP][$];
    logic [3:0]  rs_q [$];

    leaf_rx_demux #(
        .LEAF_ADDR (LEAF),
        .NUM_PORTS (NP),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .din_leaf_bft2interface(din),
        .dout_data             (dout_data),
        .dout_valid            (dout_valid),
        .dout_ready            (dout_ready),
        .resend                (resend),
        .resend_port           (resend_port),
        .drop_cnt              (drop_cnt),
        .misroute_cnt          (misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] mk(input logic [4:0] leaf, input logic [3:0] port,
                                       input logic [31:0] d);
        return {1'b1, leaf, port, 7'h0, d};
    endfunction

    // Drives one packet for one cycle and records the expected outcome.
    task automatic send(input logic [4:0] leaf, input logic [3:0] port,
                        input logic [31:0] d, input int mode);
        din = mk(leaf, port, d);
        if (mode == ACC) exp_q[port].push_back(d);
        if (mode == DRP) rs_q.push_back(port);
        cyc();
        din = '0;
    endtask

    task automatic wait_drain(input int p, input int budget);
        int n = 0;
        while (exp_q[p].size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk($sformatf("drain_port%0d_left", p), 64'(exp_q[p].size()), 64'd0);
        exp_q[p].delete();
    endtask

    task automatic scen1();
        dout_ready = '1;
        send(LEAF, 4'd1, 32'hA5A5_0001, ACC);
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(dout_valid[1]), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(dout_valid[1]), 64'd1);
        chk("lat_cycle2_data", 64'(dout_data[63:32]), 64'hA5A5_0001);
        cyc();
        wait_drain(1, 5);
    endtask

    // Monitor: compares every handshake and every resend pulse against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int p = 0; p < NP; p++) begin
                if (dout_valid[p] && dout_ready[p]) begin
                    if (exp_q[p].size() == 0) begin
                        chk($sformatf("unexpected_pop_port%0d", p), 64'(dout_data[p*32 +: 32]), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk($sformatf("pop_data_port%0d", p), 64'(dout_data[p*32 +: 32]), 64'(exp_q[p].pop_front()));
                    end
                end
            end
            if (resend) begin
                if (rs_q.size() == 0) begin
                    chk("unexpected_resend", 64'(resend_port), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("resend_port", 64'(resend_port), 64'(rs_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        din        = '0;
        dout_ready = '0;

        // 1: outputs held at zero under reset with random traffic
        for (int i = 0; i < 4; i++) begin
            cyc();
            din        = {17'($urandom), 32'($urandom)};
            dout_ready = 4'($urandom);
            @(negedge clk);
            chk("rst_out_zero", {dout_data[63:0] | dout_data[127:64], 4'(dout_valid)} , 64'd0);
        end
        chk("rst_resend", {59'd0, resend, resend_port}, 64'd0);
        chk("rst_counters", {32'd0, drop_cnt, misroute_cnt}, 64'd0);
        cyc();
        din = '0;
        dout_ready = '1;
        reset_n = 1'b1;
        cyc();
        scen1();

        // 2: in-order delivery of back-to-back packets
        for (int i = 0; i < 10; i++) send(LEAF, 4'd0, 32'(i), ACC);
        wait_drain(0, 20);
        chk("s2_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("s2_misroute_cnt", 64'(misroute_cnt), 64'd0);

        // 3: overflow of port 2
        dout_ready[2] = 1'b0;
        for (int i = 0; i < 17; i++) send(LEAF, 4'd2, 32'(i), (i < 16) ? ACC : DRP);
        repeat (3) cyc();
        chk("s3_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("s3_resend_port_hold", 64'(resend_port), 64'd2);
        chk("s3_resend_q_empty", 64'(rs_q.size()), 64'd0);
        dout_ready[2] = 1'b1;
        wait_drain(2, 40);

        // 4: full plus simultaneous pop on port 3
        dout_ready[3] = 1'b0;
        for (int i = 0; i < 16; i++) send(LEAF, 4'd3, 32'(100 + i), ACC);
        repeat (3) cyc();
        din = mk(LEAF, 4'd3, 32'hDEAD);
        exp_q[3].push_back(32'hDEAD);
        cyc();
        din = '0;
        dout_ready[3] = 1'b1;
        cyc();
        dout_ready[3] = 1'b0;
        repeat (2) cyc();
        chk("s4_still_full_valid", 64'(dout_valid[3]), 64'd1);
        send(LEAF, 4'd3, 32'hBEEF, DRP);
        repeat (3) cyc();
        chk("s4_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("s4_resend_q_empty", 64'(rs_q.size()), 64'd0);
        dout_ready[3] = 1'b1;
        wait_drain(3, 40);

        // 5: misroutes
        send(LEAF + 5'd1, 4'd0, 32'h1111, MIS);
        send(LEAF, 4'(NP), 32'h2222, MIS);
        repeat (3) cyc();
        chk("s5_misroute_cnt", 64'(misroute_cnt), 64'd2);
        chk("s5_no_valid", 64'(dout_valid), 64'd0);
        chk("s5_drop_cnt", 64'(drop_cnt), 64'd2);

        // 6: asynchronous reset while three FIFOs hold data
        dout_ready = '0;
        send(LEAF, 4'd0, 32'h10, ACC);
        send(LEAF, 4'd1, 32'h11, ACC);
        send(LEAF, 4'd2, 32'h12, ACC);
        repeat (3) cyc();
        chk("s6_pre_valid", 64'(dout_valid), 64'h7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_async_valid", 64'(dout_valid), 64'd0);
        chk("s6_async_counters", {32'd0, drop_cnt, misroute_cnt}, 64'd0);
        chk("s6_async_resend_port", 64'(resend_port), 64'd0);
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        rs_q.delete();
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        scen1();
        repeat (3) cyc();
        for (int p = 0; p < NP; p++) chk($sformatf("end_q%0d_empty", p), 64'(exp_q[p].size()), 64'd0);
        chk("end_rs_q_empty", 64'(rs_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
